serial_tx: RTL and testbench

Parallel-in, serial-out transmitter. It is the transmit end of the team's bit-serial link and the counterpart of the `serial` receiver. It accepts 64-bit words with a length over a push/stop handshake and buffers them in a small FIFO. It then emits each word MSB-first (bit lenin-1 down to bit 0) as a serial bit stream with a last-bit flag, honouring downstream backpressure.

---
 rtl/serial_tx.sv | 121 ++++++++++++
 tb/tb_serial_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx: buffers 64-bit words with a length in a small FIFO and sends each one MSB-first as a bit stream.
// Optional macro SERIAL_TX_LENCHK_EN drops words of illegal length and pulses errout; otherwise the length is clamped to 1..64.
module serial_tx #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  input  logic [63:0] datain,
  input  logic [6:0]  lenin,
  output logic        stopout,
  output logic        pushout,
  output logic        dataout,
  output logic        lastout,
  input  logic        stopin,
  output logic        errout
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [63:0] mem_data [DEPTH];
  logic [6:0]  mem_len  [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0] shreg_q, shreg_d;
  logic [6:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;

  logic        full, empty, offer, wr_en, pop, xfer, last_bit;
  logic [6:0]  len_eff;
  logic [63:0] head_data;
  logic [6:0]  head_len;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign offer = pushin && !full;

`ifdef SERIAL_TX_LENCHK_EN
  logic len_legal;
  logic errout_q, errout_d;

  assign len_legal = (lenin != 7'd0) && (lenin <= 7'd64);
  assign wr_en     = offer && len_legal;
  assign len_eff   = lenin;
  assign errout_d  = offer && !len_legal;

  always_ff @(posedge clk) begin
    if (rst) errout_q <= 1'b0;
    else     errout_q <= errout_d;
  end
  assign errout = errout_q;
`else
  assign wr_en   = offer;
  assign len_eff = (lenin == 7'd0) ? 7'd1 : ((lenin > 7'd64) ? 7'd64 : lenin);
  assign errout  = 1'b0;
`endif

  // Storage has no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q[AW-1:0]] <= datain;
      mem_len[wr_ptr_q[AW-1:0]]  <= len_eff;
    end
  end

  // Head is read combinationally so the next word can load on the same edge as the previous last bit.
  assign head_data = mem_data[rd_ptr_q[AW-1:0]];
  assign head_len  = mem_len[rd_ptr_q[AW-1:0]];

  assign xfer     = (state_q == SHIFT) && !stopin;
  assign last_bit = (cnt_q == 7'd1);
  assign pop      = !empty && ((state_q == IDLE) || (xfer && last_bit));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= 64'd0;
      cnt_q    <= 7'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    case (state_q)
      IDLE:    if (!empty) state_d = SHIFT;
      SHIFT:   if (xfer && last_bit && empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shreg_d = head_data << (7'd64 - head_len);
      cnt_d   = head_len;
    end else if (xfer) begin
      shreg_d = {shreg_q[62:0], 1'b0};
      cnt_d   = cnt_q - 7'd1;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    stopout = full;
    pushout = (state_q == SHIFT);
    dataout = shreg_q[63];
    lastout = (state_q == SHIFT) && last_bit;
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed and random-stall bench for serial_tx; define SERIAL_TX_LENCHK_EN for both files to exercise the length check.
module tb_serial_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        pushin;
  logic [63:0] datain;
  logic [6:0]  lenin;
  logic        stopout, pushout, dataout, lastout, stopin, errout;

  int checks = 0;
  int failures = 0;

  localparam int NRAND = 400;

  serial_tx #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pushin(pushin), .datain(datain), .lenin(lenin),
    .stopout(stopout), .pushout(pushout), .dataout(dataout), .lastout(lastout),
    .stopin(stopin), .errout(errout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mask_len(input logic [63:0] d, input int l);
    if (l >= 64) return d;
    return d & ((64'd1 << l) - 64'd1);
  endfunction

  task automatic push_word(input logic [63:0] d, input logic [6:0] l);
    pushin = 1'b1;
    datain = d;
    lenin  = l;
    @(posedge clk);
    #1;
    pushin = 1'b0;
  endtask

  // Reassembles one word from the stream with stopin=0; waitc counts idle cycles before the first bit.
  task automatic collect_word(output logic [63:0] d, output int l, output int waitc, output bit ok);
    d = 64'd0; l = 0; waitc = 0; ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (pushout) begin
        d = {d[62:0], dataout};
        l++;
        if (lastout) begin
          ok = 1'b1;
          break;
        end
      end else if (l == 0) begin
        waitc++;
      end
    end
    $display("rx word len=%0d data=%h wait=%0d", l, d, waitc);
  endtask

  task automatic test_reset();
    rst = 1'b1; pushin = 1'b0; stopin = 1'b0; datain = 64'd0; lenin = 7'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stopout, pushout, dataout, lastout, errout} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {stopout, pushout, dataout, lastout, errout});
    end
  endtask

  task automatic test_single_word();
    logic [2:0] exp_bits;
    exp_bits = 3'b101;
    push_word(64'h5, 7'd3);
    @(negedge clk);
    checks++;
    if (pushout !== 1'b0) begin
      failures++;
      $display("FAIL single_latency pushout got=%b exp=0", pushout);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({pushout, dataout, lastout} !== {1'b1, exp_bits[2-i], (i == 2)}) begin
        failures++;
        $display("FAIL single_bit%0d got=%b exp=%b", i, {pushout, dataout, lastout},
                 {1'b1, exp_bits[2-i], (i == 2)});
      end
    end
    @(negedge clk);
    checks++;
    if (pushout !== 1'b0) begin
      failures++;
      $display("FAIL single_underflow pushout got=%b exp=0", pushout);
    end
    $display("tx word len=3 data=5 done");
  endtask

  task automatic test_back_to_back();
    logic [63:0] d; int l, w; bit ok;
    push_word(64'h8000_0000_0000_0001, 7'd64);
    push_word(64'h1, 7'd1);
    collect_word(d, l, w, ok);
    checks++;
    if (!ok || l != 64 || d !== 64'h8000_0000_0000_0001) begin
      failures++;
      $display("FAIL b2b_word0 got len=%0d data=%h exp len=64 data=8000000000000001", l, d);
    end
    collect_word(d, l, w, ok);
    checks++;
    if (!ok || l != 1 || d !== 64'h1 || w != 0) begin
      failures++;
      $display("FAIL b2b_word1 got len=%0d data=%h gap=%0d exp len=1 data=1 gap=0", l, d, w);
    end
    @(negedge clk);
    checks++;
    if (pushout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_underflow pushout got=%b exp=0", pushout);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] dv [5];
    int          lv [5];
    logic [63:0] d; int l, w, extra; bit ok;
    dv[0] = 64'h1F;               lv[0] = 5;
    dv[1] = 64'hA5;               lv[1] = 8;
    dv[2] = 64'h0000_0000_0000_0C3A; lv[2] = 12;
    dv[3] = 64'h6;                lv[3] = 3;
    dv[4] = 64'hDEAD_BEEF_0123_4567; lv[4] = 64;
    stopin = 1'b1;
    for (int i = 0; i < 4; i++) push_word(dv[i], 7'(lv[i]));
    checks++;
    if (stopout !== 1'b0) begin
      failures++;
      $display("FAIL bp_not_full_yet stopout got=%b exp=0", stopout);
    end
    push_word(dv[4], 7'(lv[4]));
    checks++;
    if (stopout !== 1'b1) begin
      failures++;
      $display("FAIL bp_full stopout got=%b exp=1", stopout);
    end
    push_word(64'h3, 7'd2);
    checks++;
    if (stopout !== 1'b1 || pushout !== 1'b1 || dataout !== 1'b1 || lastout !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold got=%b exp=1110", {stopout, pushout, dataout, lastout});
    end
    stopin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      collect_word(d, l, w, ok);
      checks++;
      if (!ok || l != lv[i] || d !== dv[i]) begin
        failures++;
        $display("FAIL bp_word%0d got len=%0d data=%h exp len=%0d data=%h", i, l, d, lv[i], dv[i]);
      end
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (pushout) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL bp_sixth_rejected extra_bits got=%0d exp=0", extra);
    end
  endtask

  task automatic test_random_stall();
    logic [63:0] exp_d [$];
    int          exp_l [$];
    logic [63:0] rd, ed;
    int          rl, el, sent, got;
    logic        prev_stall, p_po, p_do, p_lo;
    sent = 0; got = 0; rd = 64'd0; rl = 0; prev_stall = 1'b0;
    p_po = 1'b0; p_do = 1'b0; p_lo = 1'b0;
    for (int cyc = 0; cyc < 60000 && got < NRAND; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if ({pushout, dataout, lastout} !== {p_po, p_do, p_lo}) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got=%b exp=%b", cyc, {pushout, dataout, lastout}, {p_po, p_do, p_lo});
        end
      end
      stopin = ($urandom_range(0, 3) == 0);
      if (sent < NRAND) begin
        pushin = 1'($urandom_range(0, 1));
        datain = {$urandom, $urandom};
        lenin  = 7'($urandom_range(1, 64));
      end else begin
        pushin = 1'b0;
      end
      if (pushin && !stopout) begin
        exp_d.push_back(mask_len(datain, int'(lenin)));
        exp_l.push_back(int'(lenin));
        sent++;
      end
      if (pushout && !stopin) begin
        rd = {rd[62:0], dataout};
        rl++;
        if (lastout) begin
          ed = 64'd0; el = 0;
          if (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
          end
          checks++;
          if (rd !== ed || rl != el) begin
            failures++;
            $display("FAIL rand_word%0d got len=%0d data=%h exp len=%0d data=%h", got, rl, rd, el, ed);
          end
          got++;
          rd = 64'd0;
          rl = 0;
        end
      end
      prev_stall = pushout && stopin;
      p_po = pushout; p_do = dataout; p_lo = lastout;
    end
    pushin = 1'b0;
    stopin = 1'b0;
    checks++;
    if (got != NRAND) begin
      failures++;
      $display("FAIL rand_complete words got=%0d exp=%0d", got, NRAND);
    end
    $display("random stall run words=%0d", got);
  endtask

  task automatic test_mid_word_reset();
    logic [63:0] d; int l, w, n, seen; bit ok;
    push_word(64'h00AB_CDEF_1234, 7'd40);
    push_word(64'h7, 7'd3);
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (pushout) n++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stopout, pushout, dataout, lastout, errout} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b exp=00000", {stopout, pushout, dataout, lastout, errout});
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (pushout || lastout) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midrst_fifo_empty active_cycles got=%0d exp=0", seen);
    end
    push_word(64'h2D, 7'd6);
    collect_word(d, l, w, ok);
    checks++;
    if (!ok || l != 6 || d !== 64'h2D) begin
      failures++;
      $display("FAIL midrst_after got len=%0d data=%h exp len=6 data=2d", l, d);
    end
  endtask

  task automatic test_length_handling();
    logic [63:0] d; int l, w; bit ok;
`ifdef SERIAL_TX_LENCHK_EN
    push_word(64'hF, 7'd0);
    @(negedge clk);
    checks++;
    if (errout !== 1'b1) begin
      failures++;
      $display("FAIL lenchk_err0 errout got=%b exp=1", errout);
    end
    push_word(64'hF, 7'd65);
    @(negedge clk);
    checks++;
    if (errout !== 1'b1) begin
      failures++;
      $display("FAIL lenchk_err65 errout got=%b exp=1", errout);
    end
    @(negedge clk);
    checks++;
    if (errout !== 1'b0 || pushout !== 1'b0) begin
      failures++;
      $display("FAIL lenchk_dropped errout,pushout got=%b%b exp=00", errout, pushout);
    end
    push_word(64'hA5, 7'd8);
    collect_word(d, l, w, ok);
    checks++;
    if (!ok || l != 8 || d !== 64'hA5) begin
      failures++;
      $display("FAIL lenchk_legal got len=%0d data=%h exp len=8 data=a5", l, d);
    end
`else
    push_word(64'h1, 7'd0);
    collect_word(d, l, w, ok);
    checks++;
    if (!ok || l != 1 || d !== 64'h1 || errout !== 1'b0) begin
      failures++;
      $display("FAIL clamp_len0 got len=%0d data=%h err=%b exp len=1 data=1 err=0", l, d, errout);
    end
    push_word(64'hC000_0000_0000_0003, 7'd100);
    collect_word(d, l, w, ok);
    checks++;
    if (!ok || l != 64 || d !== 64'hC000_0000_0000_0003 || errout !== 1'b0) begin
      failures++;
      $display("FAIL clamp_len100 got len=%0d data=%h err=%b exp len=64 data=c000000000000003 err=0", l, d, errout);
    end
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (pushout !== 1'b0) begin
      failures++;
      $display("FAIL len_no_extra pushout got=%b exp=0", pushout);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_mid_word_reset();
    test_length_handling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
